// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART receiver.
//   parity_mode_e : parity configuration (none / even / odd)
//   rx_state_e    : receiver FSM states
//   calc_parity   : expected parity bit for a payload (unused upper bits must be 0)
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Payload is passed zero-extended to 9 bits so the XOR ignores unused bits.
  function automatic logic calc_parity(input logic [8:0] data, input parity_mode_e mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset (both flops load RST_VAL)
//   d    in  asynchronous input
//   q    out synchronized output, 2 cycles of latency
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (configurable data bits, parity,
// stop bits) with start-bit glitch rejection, parity/framing/overrun errors
// and a valid/ready output.
//
// Handshake: a frame is transferred on every clk edge where recv_valid and
// recv_ready are both high. recv_valid stays high, with byte_recv and the
// error flags stable, until that transfer. A frame completing while the
// previous one is still unread is dropped and overrun_err pulses once.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   data_in      in   asynchronous serial line, idles high
//   byte_recv    out  received payload (LSB first on the wire)
//   recv_valid   out  byte_recv holds an unread frame
//   recv_ready   in   consumer accepts the frame
//   parity_err   out  parity mismatch on the frame in byte_recv
//   frame_err    out  a stop bit sampled low on the frame in byte_recv
//   overrun_err  out  one-cycle pulse when a completed frame is dropped
//
// Build option: define UART_RX_MAJORITY_EN to take every bit decision as the
// 2-of-3 majority of the samples around the sample point.
//
// FSM state is held in r_state (type rx_state_e) for observation.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] byte_recv,
  output logic                 recv_valid,
  input  logic                 recv_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID      = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [1:0]    PMODE_BITS = PARITY_MODE[1:0];
  localparam parity_mode_e  PMODE = parity_mode_e'(PMODE_BITS);

  logic                 w_rx_s;
  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [CW-1:0]        r_clk_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_byte;
  logic                 r_valid;
  logic                 r_perr_o;
  logic                 r_ferr_o;
  logic                 r_ovr;
  logic                 w_at_sp;
  logic                 w_bit_ev;
  logic                 w_bit_val;
  logic                 w_complete;
  logic                 w_ferr_fin;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_in),
    .q   (w_rx_s)
  );

  // Start bit is checked at its centre; every later bit is sampled one full
  // bit period after the previous decision point, landing on bit centres.
  assign w_at_sp = (r_state != IDLE) &&
                   ((r_state == START) ? (r_clk_cnt == MID) : (r_clk_cnt == LAST));

`ifdef UART_RX_MAJORITY_EN
  // Decision is deferred one cycle so the sample after the sample point is
  // available; the counter still restarts at the sample point itself.
  logic       r_pend;
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_hist <= 2'b11;
    end else begin
      r_pend <= w_at_sp;
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_bit_ev  = r_pend;
  assign w_bit_val = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
  assign w_bit_ev  = w_at_sp;
  assign w_bit_val = w_rx_s;
`endif

  assign w_ferr_fin = r_ferr | ~w_bit_val;

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // r_armed blocks re-triggering on a line still low after a frame error.
        if (r_armed && !w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (w_bit_ev) w_state_nxt = w_bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (w_bit_ev && (r_bit_idx == BIT_LAST))
          w_state_nxt = (PMODE != PAR_NONE) ? PARITY : STOP;
      end
      PARITY: begin
        if (w_bit_ev) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_ev && (r_stop_idx == STOP_LAST)) begin
          w_state_nxt = IDLE;
          w_complete  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_armed    <= 1'b1;
      r_byte     <= '0;
      r_valid    <= 1'b0;
      r_perr_o   <= 1'b0;
      r_ferr_o   <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ovr   <= 1'b0;

      if (r_state == IDLE || w_at_sp) r_clk_cnt <= '0;
      else                            r_clk_cnt <= r_clk_cnt + 1'b1;

      if (r_state == IDLE) begin
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
      end else if (w_bit_ev) begin
        if (r_state == DATA) begin
          r_shift   <= {w_bit_val, r_shift[DATA_BITS-1:1]};
          r_bit_idx <= (r_bit_idx == BIT_LAST) ? '0 : r_bit_idx + 1'b1;
        end
        if (r_state == PARITY) r_perr <= (w_bit_val != calc_parity(9'(r_shift), PMODE));
        if (r_state == STOP) begin
          r_stop_idx <= ~r_stop_idx;
          r_ferr     <= w_ferr_fin;
        end
      end

      if (w_complete)                       r_armed <= 1'b0;
      else if (r_state == IDLE && w_rx_s)   r_armed <= 1'b1;

      // Completion wins over a same-cycle acceptance.
      if (w_complete) begin
        if (!r_valid || recv_ready) begin
          r_byte   <= r_shift;
          r_perr_o <= r_perr;
          r_ferr_o <= w_ferr_fin;
          r_valid  <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && recv_ready) begin
        r_valid  <= 1'b0;
        r_perr_o <= 1'b0;
        r_ferr_o <= 1'b0;
      end
    end
  end

  assign byte_recv   = r_byte;
  assign recv_valid  = r_valid;
  assign parity_err  = r_perr_o;
  assign frame_err   = r_ferr_o;
  assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: two receiver instances (8N1 at 87 clk/bit, and 7E2 at
// 16 clk/bit) driven with directed frames. Expected frames are queued when
// sent; monitors pop and compare whenever a frame is transferred.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB_A = 87;
  localparam int CPB_B = 16;

  logic       clk;
  logic       rst_a, rst_b;
  logic       rx_a, rx_b;
  logic [7:0] byte_a;
  logic [6:0] byte_b;
  logic       valid_a, valid_b, ready_a, ready_b;
  logic       perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;

  int checks = 0;
  int errors = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_b = 0;
  bit prev_acc_a = 0;
  bit prev_acc_b = 0;

  // entry = {ferr, perr, data[8:0]}
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];
  logic [10:0] e_a, e_b;

  uart_rx_param #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst_a), .data_in(rx_a), .byte_recv(byte_a), .recv_valid(valid_a),
    .recv_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst_b), .data_in(rx_b), .byte_recv(byte_b), .recv_valid(valid_b),
    .recv_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input int sel, input logic v, input int ncyc);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input int cpb, input logic [8:0] d, input int nbits,
                            input bit has_par, input logic par, input int nstop,
                            input logic [1:0] stop_pat);
    drive_bit(sel, 1'b0, cpb);
    for (int i = 0; i < nbits; i++) drive_bit(sel, d[i], cpb);
    if (has_par) drive_bit(sel, par, cpb);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stop_pat[i], cpb);
  endtask

  // monitors / scoreboard
  always begin
    @(negedge clk);
    #1;
    if (rst_a) begin
      prev_acc_a = 1'b0;
    end else begin
      if (prev_acc_a) check("a_valid_clear_after_accept", valid_a, 0);
      prev_acc_a = valid_a && ready_a;
      if (ovr_a) ovr_cnt_a++;
      if (valid_a && ready_a) begin
        if (exp_a.size() == 0) begin
          check("a_unexpected_frame", valid_a, 0);
        end else begin
          e_a = exp_a.pop_front();
          check("a_byte", byte_a, e_a[7:0]);
          check("a_parity_err", perr_a, e_a[9]);
          check("a_frame_err", ferr_a, e_a[10]);
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (rst_b) begin
      prev_acc_b = 1'b0;
    end else begin
      if (prev_acc_b) check("b_valid_clear_after_accept", valid_b, 0);
      prev_acc_b = valid_b && ready_b;
      if (ovr_b) ovr_cnt_b++;
      if (valid_b && ready_b) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected_frame", valid_b, 0);
        end else begin
          e_b = exp_b.pop_front();
          check("b_byte", byte_b, e_b[6:0]);
          check("b_parity_err", perr_b, e_b[9]);
          check("b_frame_err", ferr_b, e_b[10]);
        end
      end
    end
  end

  initial begin
    rx_a = 1'b1; rx_b = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("a_reset_byte", byte_a, 0);
    check("a_reset_valid", valid_a, 0);
    check("a_reset_perr", perr_a, 0);
    check("a_reset_ferr", ferr_a, 0);
    check("a_reset_ovr", ovr_a, 0);
    check("a_reset_state", 32'(dut_a.r_state), 32'(IDLE));
    check("b_reset_byte", byte_b, 0);
    check("b_reset_valid", valid_b, 0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (10) @(negedge clk);

    // 8N1 basic frames
    exp_a.push_back({2'b00, 9'h055});
    send_frame(0, CPB_A, 9'h055, 8, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1, 2 * CPB_A);
    exp_a.push_back({2'b00, 9'h0FF});
    send_frame(0, CPB_A, 9'h0FF, 8, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1, CPB_A);
    exp_a.push_back({2'b00, 9'h000});
    send_frame(0, CPB_A, 9'h000, 8, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1, CPB_A);

    // stop bit low, line held low as a break, then a clean frame
    exp_a.push_back({2'b10, 9'h0A3});
    send_frame(0, CPB_A, 9'h0A3, 8, 0, 1'b0, 1, 2'b00);
    drive_bit(0, 1'b0, 3 * CPB_A);
    drive_bit(0, 1'b1, CPB_A);
    exp_a.push_back({2'b00, 9'h05A});
    send_frame(0, CPB_A, 9'h05A, 8, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1, CPB_A);

    // start-bit glitch
    drive_bit(0, 1'b0, 20);
    drive_bit(0, 1'b1, 2 * CPB_A);
    #1;
    check("a_glitch_no_valid", valid_a, 0);
    check("a_glitch_state_idle", 32'(dut_a.r_state), 32'(IDLE));

    // overrun: consumer stalled
    ready_a = 1'b0;
    exp_a.push_back({2'b00, 9'h012});
    send_frame(0, CPB_A, 9'h012, 8, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1, CPB_A);
    send_frame(0, CPB_A, 9'h034, 8, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1, CPB_A);
    #1;
    check("a_overrun_keeps_byte", byte_a, 8'h12);
    check("a_overrun_valid_held", valid_a, 1);
    check("a_overrun_pulse_count", ovr_cnt_a, 1);
    @(negedge clk);
    ready_a = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("a_valid_clear_after_ready", valid_a, 0);

    // reset during data bit 4 of 0xC3
    drive_bit(0, 1'b0, CPB_A);
    for (int i = 0; i < 4; i++) drive_bit(0, (8'hC3 >> i) & 8'h01, CPB_A);
    drive_bit(0, 1'b0, 40);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("a_midreset_byte", byte_a, 0);
    check("a_midreset_valid", valid_a, 0);
    check("a_midreset_flags", {29'b0, perr_a, ferr_a, ovr_a}, 0);
    check("a_midreset_state", 32'(dut_a.r_state), 32'(IDLE));
    @(negedge clk);
    rst_a = 1'b0;
    drive_bit(0, 1'b1, 2 * CPB_A);
    exp_a.push_back({2'b00, 9'h0C3});
    send_frame(0, CPB_A, 9'h0C3, 8, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1, 2 * CPB_A);

    // 7 data bits, even parity, 2 stop bits
    exp_b.push_back({2'b01, 9'h041});   // 0x41 has even ones -> parity bit 1 is wrong
    send_frame(1, CPB_B, 9'h041, 7, 1, 1'b1, 2, 2'b11);
    drive_bit(1, 1'b1, CPB_B);
    exp_b.push_back({2'b00, 9'h041});
    send_frame(1, CPB_B, 9'h041, 7, 1, 1'b0, 2, 2'b11);
    drive_bit(1, 1'b1, CPB_B);
    exp_b.push_back({2'b00, 9'h03C});
    send_frame(1, CPB_B, 9'h03C, 7, 1, 1'b0, 2, 2'b11);
    drive_bit(1, 1'b1, CPB_B);
    exp_b.push_back({2'b00, 9'h07F});
    send_frame(1, CPB_B, 9'h07F, 7, 1, 1'b1, 2, 2'b11);
    drive_bit(1, 1'b1, CPB_B);
    exp_b.push_back({2'b10, 9'h015});   // second stop bit low
    send_frame(1, CPB_B, 9'h015, 7, 1, 1'b1, 2, 2'b01);
    drive_bit(1, 1'b1, 2 * CPB_B);
    exp_b.push_back({2'b00, 9'h02A});
    send_frame(1, CPB_B, 9'h02A, 7, 1, 1'b1, 2, 2'b11);
    drive_bit(1, 1'b1, 3 * CPB_B);

    #1;
    check("a_frames_outstanding", exp_a.size(), 0);
    check("b_frames_outstanding", exp_b.size(), 0);
    check("a_overrun_total", ovr_cnt_a, 1);
    check("b_overrun_total", ovr_cnt_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
